// File: rtl/mc_control_unit.sv
// Moore control FSM for the multicycle MIPS datapath.
// The optional exception path (overflow / illegal instruction -> EXC) is built only
// when the macro CTRL_EXC_EN is defined. Otherwise EPC_w is tied low and overflow is ignored.
module mc_control_unit #(
    parameter int unsigned RESET_CYCLES = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] OPCODE,
    input  logic [5:0] FUNCT,
    input  logic       zero,
    input  logic       overflow,
    output logic       PC_w,
    output logic       MEM_w,
    output logic       IR_w,
    output logic       RB_w,
    output logic       AB_w,
    output logic       MEM_DATA_REG_w,
    output logic       ALUOUT_w,
    output logic       EPC_w,
    output logic       IorD,
    output logic [1:0] M_WREG,
    output logic [1:0] MemToReg,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [2:0] ALU_op,
    output logic [1:0] PC_src
);

    typedef enum logic [4:0] {
        StReset, StFetch, StFetchWait, StDecode, StExecR, StWbR, StExecI, StWbI,
        StMemAddr, StMemRd, StMemRdWait, StMemWb, StMemWr, StBranch, StJump, StLui,
        StIllegal
`ifdef CTRL_EXC_EN
        , StExc
`endif
    } state_t;

    localparam logic [2:0] AluAdd = 3'b001;
    localparam logic [2:0] AluSub = 3'b010;
    localparam logic [2:0] AluAnd = 3'b011;
    localparam logic [2:0] AluOr  = 3'b100;
    localparam logic [2:0] AluSlt = 3'b101;
    localparam logic [3:0] RstLast = 4'(RESET_CYCLES - 1);

    state_t     state_q, state_d;
    state_t     bad_st;
    logic [3:0] rst_cnt_q;

`ifndef CTRL_EXC_EN
    logic unused_overflow;
    assign unused_overflow = overflow;
`endif

    // State register; reset forces RESET asynchronously so all outputs drop at once.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= StReset;
        else        state_q <= state_d;
    end

    // Counts cycles spent in RESET after reset release.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                 rst_cnt_q <= 4'd0;
        else if (state_q == StReset) rst_cnt_q <= rst_cnt_q + 4'd1;
    end

    // Next-state and Moore output decode.
    always_comb begin
        state_d        = state_q;
        PC_w           = 1'b0;
        MEM_w          = 1'b0;
        IR_w           = 1'b0;
        RB_w           = 1'b0;
        AB_w           = 1'b0;
        MEM_DATA_REG_w = 1'b0;
        ALUOUT_w       = 1'b0;
        EPC_w          = 1'b0;
        IorD           = 1'b0;
        M_WREG         = 2'd0;
        MemToReg       = 2'd0;
        ALUSrcA        = 1'b0;
        ALUSrcB        = 2'd0;
        ALU_op         = 3'b000;
        PC_src         = 2'd0;
`ifdef CTRL_EXC_EN
        bad_st = StExc;     // illegal encodings trap straight away
`else
        bad_st = StIllegal; // illegal encodings become a NOP
`endif
        case (state_q)
            StReset: if (rst_cnt_q == RstLast) state_d = StFetch;
            StFetch: begin
                ALUSrcB = 2'd1;
                ALU_op  = AluAdd;
                state_d = StFetchWait;
            end
            StFetchWait: begin
                IR_w    = 1'b1;
                PC_w    = 1'b1;
                ALUSrcB = 2'd1;
                ALU_op  = AluAdd;
                state_d = StDecode;
            end
            StDecode: begin
                AB_w     = 1'b1;
                ALUOUT_w = 1'b1;
                ALUSrcB  = 2'd3;
                ALU_op   = AluAdd;
                case (OPCODE)
                    6'h00:        state_d = StExecR;
                    6'h08:        state_d = StExecI;
                    6'h23, 6'h2B: state_d = StMemAddr;
                    6'h04, 6'h05: state_d = StBranch;
                    6'h02:        state_d = StJump;
                    6'h0F:        state_d = StLui;
                    default:      state_d = bad_st;
                endcase
            end
            StExecR: begin
                ALUSrcA  = 1'b1;
                ALUOUT_w = 1'b1;
                state_d  = StWbR;
                case (FUNCT)
                    6'h20:   ALU_op = AluAdd;
                    6'h22:   ALU_op = AluSub;
                    6'h24:   ALU_op = AluAnd;
                    6'h25:   ALU_op = AluOr;
                    6'h2A:   ALU_op = AluSlt;
                    default: begin
                        ALUOUT_w = 1'b0;
                        state_d  = bad_st;
                    end
                endcase
`ifdef CTRL_EXC_EN
                if (overflow && (FUNCT == 6'h20 || FUNCT == 6'h22)) state_d = StExc;
`endif
            end
            StWbR: begin
                RB_w    = 1'b1;
                M_WREG  = 2'd1;
                state_d = StFetch;
            end
            StExecI: begin
                ALUSrcA  = 1'b1;
                ALUSrcB  = 2'd2;
                ALU_op   = AluAdd;
                ALUOUT_w = 1'b1;
                state_d  = StWbI;
`ifdef CTRL_EXC_EN
                if (overflow) state_d = StExc;
`endif
            end
            StWbI: begin
                RB_w    = 1'b1;
                state_d = StFetch;
            end
            StMemAddr: begin
                ALUSrcA  = 1'b1;
                ALUSrcB  = 2'd2;
                ALU_op   = AluAdd;
                ALUOUT_w = 1'b1;
                state_d  = (OPCODE == 6'h2B) ? StMemWr : StMemRd;
            end
            StMemRd: begin
                IorD    = 1'b1;
                state_d = StMemRdWait;
            end
            StMemRdWait: begin
                IorD           = 1'b1;
                MEM_DATA_REG_w = 1'b1;
                state_d        = StMemWb;
            end
            StMemWb: begin
                RB_w     = 1'b1;
                MemToReg = 2'd1;
                state_d  = StFetch;
            end
            StMemWr: begin
                IorD    = 1'b1;
                MEM_w   = 1'b1;
                state_d = StFetch;
            end
            StBranch: begin
                ALUSrcA = 1'b1;
                ALU_op  = AluSub;
                PC_src  = 2'd1;
                PC_w    = ((OPCODE == 6'h04) && zero) || ((OPCODE == 6'h05) && !zero);
                state_d = StFetch;
            end
            StJump: begin
                PC_w    = 1'b1;
                PC_src  = 2'd2;
                state_d = StFetch;
            end
            StLui: begin
                RB_w     = 1'b1;
                MemToReg = 2'd2;
                state_d  = StFetch;
            end
`ifdef CTRL_EXC_EN
            StIllegal: state_d = StExc;
            StExc: begin
                EPC_w   = 1'b1;
                PC_w    = 1'b1;
                PC_src  = 2'd3;
                state_d = StFetch;
            end
`else
            StIllegal: state_d = StFetch;
`endif
            default: state_d = StReset;
        endcase
    end

endmodule

// File: tb/tb_mc_control_unit.sv
// Directed bench for mc_control_unit: a per-cycle vector table of inputs and expected
// control words, plus hand sequences for asynchronous reset and a longer RESET_CYCLES.
module tb_mc_control_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [5:0]  opcode = 6'h00;
    logic [5:0]  funct = 6'h20;
    logic        zero = 1'b0;
    logic        overflow = 1'b0;
    logic [20:0] o1, o2;

    always #5 clk = ~clk;

    mc_control_unit #(.RESET_CYCLES(1)) dut (
        .clk(clk), .reset(reset), .OPCODE(opcode), .FUNCT(funct), .zero(zero),
        .overflow(overflow), .PC_w(o1[20]), .MEM_w(o1[19]), .IR_w(o1[18]), .RB_w(o1[17]),
        .AB_w(o1[16]), .MEM_DATA_REG_w(o1[15]), .ALUOUT_w(o1[14]), .EPC_w(o1[13]),
        .IorD(o1[12]), .M_WREG(o1[11:10]), .MemToReg(o1[9:8]), .ALUSrcA(o1[7]),
        .ALUSrcB(o1[6:5]), .ALU_op(o1[4:2]), .PC_src(o1[1:0])
    );

    mc_control_unit #(.RESET_CYCLES(3)) dut3 (
        .clk(clk), .reset(reset), .OPCODE(opcode), .FUNCT(funct), .zero(zero),
        .overflow(overflow), .PC_w(o2[20]), .MEM_w(o2[19]), .IR_w(o2[18]), .RB_w(o2[17]),
        .AB_w(o2[16]), .MEM_DATA_REG_w(o2[15]), .ALUOUT_w(o2[14]), .EPC_w(o2[13]),
        .IorD(o2[12]), .M_WREG(o2[11:10]), .MemToReg(o2[9:8]), .ALUSrcA(o2[7]),
        .ALUSrcB(o2[6:5]), .ALU_op(o2[4:2]), .PC_src(o2[1:0])
    );

    typedef struct {
        logic        rst;
        logic [5:0]  op;
        logic [5:0]  fn;
        logic        z;
        logic        ov;
        logic [20:0] exp;
        string       name;
    } vec_t;

    vec_t vq[$];
    int   n_vec = 0;
    int   n_miss = 0;

    logic [20:0] e_fetch, e_fwait, e_dec, e_exr_add, e_exr_sub, e_exr_and, e_exr_or;
    logic [20:0] e_exr_slt, e_exr_bad, e_wbr, e_exi, e_wbi, e_mrd, e_mrdw, e_mwb, e_mwr;
    logic [20:0] e_brt, e_brn, e_jmp, e_lui, e_exc;

    function automatic logic [20:0] mk(
        input logic pcw, input logic memw, input logic irw, input logic rbw,
        input logic abw, input logic mdrw, input logic aluw, input logic epcw,
        input logic iord, input logic [1:0] mw, input logic [1:0] mtr, input logic asa,
        input logic [1:0] asb, input logic [2:0] op, input logic [1:0] psrc);
        return {pcw, memw, irw, rbw, abw, mdrw, aluw, epcw, iord, mw, mtr, asa, asb, op, psrc};
    endfunction

    task automatic push(input logic rst, input logic [5:0] op, input logic [5:0] fn,
                        input logic z, input logic ov, input logic [20:0] exp,
                        input string name);
        vec_t v;
        v.rst = rst; v.op = op; v.fn = fn; v.z = z; v.ov = ov; v.exp = exp; v.name = name;
        vq.push_back(v);
    endtask

    // Common fetch/decode prefix of every instruction.
    task automatic push_pre(input logic [5:0] op, input logic [5:0] fn, input logic z,
                            input logic ov, input string name);
        push(1'b1, op, fn, z, ov, e_fetch, {name, ".fetch"});
        push(1'b1, op, fn, z, ov, e_fwait, {name, ".fwait"});
        push(1'b1, op, fn, z, ov, e_dec,   {name, ".decode"});
    endtask

    task automatic check(input string name, input logic [20:0] act, input logic [20:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %06h expected %06h", name, act, exp);
        end
    endtask

    task automatic step;
        @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    initial begin
        e_fetch   = mk(0,0,0,0,0,0,0,0,0,2'd0,2'd0,0,2'd1,3'd1,2'd0);
        e_fwait   = mk(1,0,1,0,0,0,0,0,0,2'd0,2'd0,0,2'd1,3'd1,2'd0);
        e_dec     = mk(0,0,0,0,1,0,1,0,0,2'd0,2'd0,0,2'd3,3'd1,2'd0);
        e_exr_add = mk(0,0,0,0,0,0,1,0,0,2'd0,2'd0,1,2'd0,3'd1,2'd0);
        e_exr_sub = mk(0,0,0,0,0,0,1,0,0,2'd0,2'd0,1,2'd0,3'd2,2'd0);
        e_exr_and = mk(0,0,0,0,0,0,1,0,0,2'd0,2'd0,1,2'd0,3'd3,2'd0);
        e_exr_or  = mk(0,0,0,0,0,0,1,0,0,2'd0,2'd0,1,2'd0,3'd4,2'd0);
        e_exr_slt = mk(0,0,0,0,0,0,1,0,0,2'd0,2'd0,1,2'd0,3'd5,2'd0);
        e_exr_bad = mk(0,0,0,0,0,0,0,0,0,2'd0,2'd0,1,2'd0,3'd0,2'd0);
        e_wbr     = mk(0,0,0,1,0,0,0,0,0,2'd1,2'd0,0,2'd0,3'd0,2'd0);
        e_exi     = mk(0,0,0,0,0,0,1,0,0,2'd0,2'd0,1,2'd2,3'd1,2'd0);
        e_wbi     = mk(0,0,0,1,0,0,0,0,0,2'd0,2'd0,0,2'd0,3'd0,2'd0);
        e_mrd     = mk(0,0,0,0,0,0,0,0,1,2'd0,2'd0,0,2'd0,3'd0,2'd0);
        e_mrdw    = mk(0,0,0,0,0,1,0,0,1,2'd0,2'd0,0,2'd0,3'd0,2'd0);
        e_mwb     = mk(0,0,0,1,0,0,0,0,0,2'd0,2'd1,0,2'd0,3'd0,2'd0);
        e_mwr     = mk(0,1,0,0,0,0,0,0,1,2'd0,2'd0,0,2'd0,3'd0,2'd0);
        e_brt     = mk(1,0,0,0,0,0,0,0,0,2'd0,2'd0,1,2'd0,3'd2,2'd1);
        e_brn     = mk(0,0,0,0,0,0,0,0,0,2'd0,2'd0,1,2'd0,3'd2,2'd1);
        e_jmp     = mk(1,0,0,0,0,0,0,0,0,2'd0,2'd0,0,2'd0,3'd0,2'd2);
        e_lui     = mk(0,0,0,1,0,0,0,0,0,2'd0,2'd2,0,2'd0,3'd0,2'd0);
        e_exc     = mk(1,0,0,0,0,0,0,1,0,2'd0,2'd0,0,2'd0,3'd0,2'd3);

        push(1'b0, 6'h00, 6'h20, 0, 0, 21'd0, "reset0");
        push(1'b0, 6'h00, 6'h20, 0, 0, 21'd0, "reset1");
        push_pre(6'h00, 6'h20, 0, 0, "add");
        push(1'b1, 6'h00, 6'h20, 0, 0, e_exr_add, "add.exec");
        push(1'b1, 6'h00, 6'h20, 0, 0, e_wbr, "add.wb");
        push_pre(6'h00, 6'h22, 0, 0, "sub");
        push(1'b1, 6'h00, 6'h22, 0, 0, e_exr_sub, "sub.exec");
        push(1'b1, 6'h00, 6'h22, 0, 0, e_wbr, "sub.wb");
        push_pre(6'h00, 6'h24, 0, 0, "and");
        push(1'b1, 6'h00, 6'h24, 0, 0, e_exr_and, "and.exec");
        push(1'b1, 6'h00, 6'h24, 0, 0, e_wbr, "and.wb");
        push_pre(6'h00, 6'h25, 0, 0, "or");
        push(1'b1, 6'h00, 6'h25, 0, 0, e_exr_or, "or.exec");
        push(1'b1, 6'h00, 6'h25, 0, 0, e_wbr, "or.wb");
        push_pre(6'h00, 6'h2A, 0, 0, "slt");
        push(1'b1, 6'h00, 6'h2A, 0, 0, e_exr_slt, "slt.exec");
        push(1'b1, 6'h00, 6'h2A, 0, 0, e_wbr, "slt.wb");
        push_pre(6'h23, 6'h00, 0, 0, "lw");
        push(1'b1, 6'h23, 6'h00, 0, 0, e_exi, "lw.addr");
        push(1'b1, 6'h23, 6'h00, 0, 0, e_mrd, "lw.rd");
        push(1'b1, 6'h23, 6'h00, 0, 0, e_mrdw, "lw.rdwait");
        push(1'b1, 6'h23, 6'h00, 0, 0, e_mwb, "lw.wb");
        push_pre(6'h2B, 6'h00, 0, 0, "sw");
        push(1'b1, 6'h2B, 6'h00, 0, 0, e_exi, "sw.addr");
        push(1'b1, 6'h2B, 6'h00, 0, 0, e_mwr, "sw.wr");
        push_pre(6'h04, 6'h00, 1, 0, "beq_t");
        push(1'b1, 6'h04, 6'h00, 1, 0, e_brt, "beq_t.br");
        push_pre(6'h04, 6'h00, 0, 0, "beq_n");
        push(1'b1, 6'h04, 6'h00, 0, 0, e_brn, "beq_n.br");
        push_pre(6'h05, 6'h00, 0, 0, "bne_t");
        push(1'b1, 6'h05, 6'h00, 0, 0, e_brt, "bne_t.br");
        push_pre(6'h05, 6'h00, 1, 0, "bne_n");
        push(1'b1, 6'h05, 6'h00, 1, 0, e_brn, "bne_n.br");
        push_pre(6'h02, 6'h00, 0, 0, "j");
        push(1'b1, 6'h02, 6'h00, 0, 0, e_jmp, "j.jump");
        push_pre(6'h0F, 6'h00, 0, 0, "lui");
        push(1'b1, 6'h0F, 6'h00, 0, 0, e_lui, "lui.wb");
        push_pre(6'h08, 6'h00, 0, 1, "addi_ov");
        push(1'b1, 6'h08, 6'h00, 0, 1, e_exi, "addi_ov.exec");
`ifdef CTRL_EXC_EN
        push(1'b1, 6'h08, 6'h00, 0, 1, e_exc, "addi_ov.exc");
`else
        push(1'b1, 6'h08, 6'h00, 0, 1, e_wbi, "addi_ov.wb");
`endif
        push_pre(6'h00, 6'h20, 0, 1, "add_ov");
        push(1'b1, 6'h00, 6'h20, 0, 1, e_exr_add, "add_ov.exec");
`ifdef CTRL_EXC_EN
        push(1'b1, 6'h00, 6'h20, 0, 1, e_exc, "add_ov.exc");
`else
        push(1'b1, 6'h00, 6'h20, 0, 1, e_wbr, "add_ov.wb");
`endif
        push_pre(6'h3F, 6'h00, 0, 0, "illop");
`ifdef CTRL_EXC_EN
        push(1'b1, 6'h3F, 6'h00, 0, 0, e_exc, "illop.exc");
`else
        push(1'b1, 6'h3F, 6'h00, 0, 0, 21'd0, "illop.nop");
`endif
        push_pre(6'h00, 6'h3F, 0, 0, "illfn");
        push(1'b1, 6'h00, 6'h3F, 0, 0, e_exr_bad, "illfn.exec");
`ifdef CTRL_EXC_EN
        push(1'b1, 6'h00, 6'h3F, 0, 0, e_exc, "illfn.exc");
`else
        push(1'b1, 6'h00, 6'h3F, 0, 0, 21'd0, "illfn.nop");
`endif
        push_pre(6'h08, 6'h00, 0, 0, "addi");
        push(1'b1, 6'h08, 6'h00, 0, 0, e_exi, "addi.exec");
        push(1'b1, 6'h08, 6'h00, 0, 0, e_wbi, "addi.wb");

        foreach (vq[i]) begin
            @(negedge clk);
            reset = vq[i].rst; opcode = vq[i].op; funct = vq[i].fn;
            zero = vq[i].z; overflow = vq[i].ov;
            @(posedge clk);
            #1;
            check(vq[i].name, o1, vq[i].exp);
        end

        // Async reset in the middle of a store: MEM_w must drop before the next edge.
        opcode = 6'h2B; funct = 6'h00; zero = 1'b0; overflow = 1'b0;
        step(); check("swr.fetch", o1, e_fetch);
        step(); step(); step();
        step(); check("swr.wr", o1, e_mwr);
        #3 reset = 1'b0;
        #1 check("swr.async_drop", o1, 21'd0);
        step(); check("swr.held", o1, 21'd0);
        @(negedge clk) reset = 1'b1;
        @(posedge clk) #1;
        check("rel.fetch", o1, e_fetch);
        check("rc3.edge1", o2, 21'd0);
        step(); check("rel.fwait", o1, e_fwait);
        check("rc3.edge2", o2, 21'd0);
        step(); check("rc3.fetch", o2, e_fetch);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
